// File: rtl/prism_counter_bank.sv
// prism_counter_bank: per-channel one-shot/auto-reload/up-compare counters with sticky maskable interrupts
module prism_counter_bank #(
  parameter int NCH = 4,
  parameter int CW  = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [5:0]     address,
  input  logic [31:0]    data_in,
  input  logic           wr_en,
  output logic [31:0]    data_out,
  input  logic           fsm_enable,
  input  logic           fsm_halt,
  input  logic [NCH-1:0] ctl_cnt,
  input  logic [NCH-1:0] ctl_load,
  output logic [NCH-1:0] cnt_flag,
  output logic           irq
);
  logic [CW-1:0]    cnt_q [NCH];
  logic [CW-1:0]    cnt_d [NCH];
  logic [CW-1:0]    pre_q [NCH];
  logic [2*NCH-1:0] mode_q;
  logic [NCH-1:0]   ien_q, pend_q, pend_d, flag_q;
  logic             irq_q;
  logic             wr_mode, wr_int;
  assign wr_mode = wr_en && address == 6'h20;
  assign wr_int  = wr_en && address == 6'h24;
  assign irq     = irq_q;
  // flags: zero reached in down modes, compare match in up mode
  always_comb begin
    cnt_flag = '0;
    for (int i = 0; i < NCH; i++)
      cnt_flag[i] = (mode_q[2*i +: 2] == 2'd1 || mode_q[2*i +: 2] == 2'd2) ? cnt_q[i] == '0 :
                    mode_q[2*i +: 2] == 2'd3 ? cnt_q[i] == pre_q[i] : 1'b0;
  end
  // next count: bus write, then hold conditions, then load, then count
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wr_en && address == 6'(8*i+4))
        cnt_d[i] = data_in[CW-1:0];
      else if (fsm_halt || mode_q[2*i +: 2] == 2'd0 || (ctl_cnt[i] && ctl_load[i]))
        cnt_d[i] = cnt_q[i];
      else if (ctl_load[i] && fsm_enable)
        cnt_d[i] = mode_q[2*i +: 2] == 2'd3 ? '0 : pre_q[i];
      else if (ctl_cnt[i])
        cnt_d[i] = mode_q[2*i +: 2] == 2'd3 ? cnt_q[i] + CW'(1) :
                   cnt_q[i] == '0 ? (mode_q[2*i +: 2] == 2'd2 ? pre_q[i] : '0) :
                   cnt_q[i] - CW'(1);
    end
  end
  // pending sets on a rising flag; a same-cycle write-1-to-clear loses to the set
  always_comb pend_d = (pend_q & ~(wr_int ? data_in[16 +: NCH] : '0)) | (cnt_flag & ~flag_q);
  // read mux, unmapped addresses read zero
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NCH; i++) begin
      if (address == 6'(8*i))   data_out = 32'(pre_q[i]);
      if (address == 6'(8*i+4)) data_out = 32'(cnt_q[i]);
    end
    if (address == 6'h20) data_out = 32'(mode_q);
    if (address == 6'h24) data_out = 32'(ien_q) | (32'(pend_q) << 16);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        pre_q[i] <= '0;
      end
      mode_q <= '0;
      ien_q  <= '0;
      pend_q <= '0;
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (wr_en && address == 6'(8*i)) pre_q[i] <= data_in[CW-1:0];
      end
      if (wr_mode) mode_q <= data_in[2*NCH-1:0];
      if (wr_int) ien_q <= data_in[NCH-1:0];
      pend_q <= pend_d;
      flag_q <= cnt_flag;
      irq_q  <= |(pend_q & ien_q);
    end
  end
endmodule

// File: tb/tb_prism_counter_bank.sv
// tb_prism_counter_bank: scoreboard bench for the counter bank
module tb_prism_counter_bank;
  logic        clk, rst, wr_en, fsm_enable, fsm_halt, irq;
  logic [5:0]  address;
  logic [31:0] data_in, data_out;
  logic [3:0]  ctl_cnt, ctl_load, cnt_flag;
  int checks = 0;
  int errors = 0;
  typedef struct {int k; logic [5:0] a; logic [31:0] v; string t;} item_t;
  item_t q[$];

  prism_counter_bank #(.NCH(4), .CW(24)) dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .wr_en(wr_en),
    .data_out(data_out), .fsm_enable(fsm_enable), .fsm_halt(fsm_halt),
    .ctl_cnt(ctl_cnt), .ctl_load(ctl_load), .cnt_flag(cnt_flag), .irq(irq)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic exp_r(input logic [5:0] a, input logic [31:0] v, input string t);
    q.push_back('{0, a, v, t});
  endtask

  task automatic exp_f(input logic [31:0] v, input string t);
    q.push_back('{1, 6'h0, v, t});
  endtask

  task automatic exp_i(input logic [31:0] v, input string t);
    q.push_back('{2, 6'h0, v, t});
  endtask

  task automatic step();
    item_t e;
    @(posedge clk);
    #1;
    wr_en = 0; ctl_cnt = 0; ctl_load = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.k == 0) begin
        address = e.a;
        #1;
        chk(e.t, data_out, e.v);
      end else if (e.k == 1) chk(e.t, 32'(cnt_flag), e.v);
      else chk(e.t, 32'(irq), e.v);
    end
  endtask

  task automatic set_wr(input logic [5:0] a, input logic [31:0] d);
    address = a; data_in = d; wr_en = 1;
  endtask

  initial begin
    rst = 1; wr_en = 0; fsm_enable = 0; fsm_halt = 0;
    address = 0; data_in = 0; ctl_cnt = 0; ctl_load = 0;
    exp_r(6'h04, 0, "rst_cnt0"); exp_r(6'h20, 0, "rst_mode");
    exp_f(0, "rst_flag"); exp_i(0, "rst_irq");
    step();
    rst = 0; fsm_enable = 1;
    // T1 one-shot countdown
    set_wr(6'h00, 5); exp_r(6'h00, 5, "t1_pre0"); step();
    set_wr(6'h20, 1); exp_f(4'b0001, "t1_flag_mode"); step();
    ctl_load = 1; exp_r(6'h04, 5, "t1_load"); exp_r(6'h24, 32'h10000, "t1_pend_mode"); step();
    set_wr(6'h24, 32'h10000); exp_r(6'h24, 0, "t1_w1c"); step();
    for (int k = 1; k <= 5; k++) begin
      ctl_cnt = 1;
      exp_r(6'h04, 32'(5 - k), $sformatf("t1_cnt%0d", k));
      exp_f(k == 5 ? 4'b0001 : 4'b0000, $sformatf("t1_flag%0d", k));
      if (k == 5) exp_r(6'h24, 0, "t1_pend_early");
      step();
    end
    ctl_cnt = 1; exp_r(6'h04, 0, "t1_hold0"); exp_r(6'h24, 32'h10000, "t1_pend"); step();
    set_wr(6'h24, 32'h10000); exp_r(6'h24, 0, "t1_clr"); step();
    // T2 auto-reload period of three
    set_wr(6'h08, 2); step();
    set_wr(6'h20, 9); exp_f(4'b0011, "t2_flag_mode"); step();
    ctl_cnt = 2; exp_r(6'h0C, 2, "t2_c1"); exp_r(6'h24, 32'h20000, "t2_p1"); step();
    ctl_cnt = 2; set_wr(6'h24, 32'h20000); exp_r(6'h0C, 1, "t2_c2"); exp_r(6'h24, 0, "t2_p2"); step();
    ctl_cnt = 2; exp_r(6'h0C, 0, "t2_c3"); exp_r(6'h24, 0, "t2_p3"); exp_f(4'b0011, "t2_f3"); step();
    ctl_cnt = 2; exp_r(6'h0C, 2, "t2_c4"); exp_r(6'h24, 32'h20000, "t2_p4"); exp_f(4'b0001, "t2_f4"); step();
    ctl_cnt = 2; set_wr(6'h24, 32'h20000); exp_r(6'h0C, 1, "t2_c5"); exp_r(6'h24, 0, "t2_p5"); step();
    ctl_cnt = 2; exp_r(6'h0C, 0, "t2_c6"); exp_r(6'h24, 0, "t2_p6"); step();
    ctl_cnt = 2; exp_r(6'h0C, 2, "t2_c7"); exp_r(6'h24, 32'h20000, "t2_p7"); step();
    set_wr(6'h24, 32'h20000); exp_r(6'h24, 0, "t2_clr"); step();
    // T3 up-compare with interrupt
    set_wr(6'h10, 3); step();
    set_wr(6'h24, 4); exp_r(6'h24, 4, "t3_ien"); step();
    set_wr(6'h20, 32'h39); exp_r(6'h20, 32'h39, "t3_mode"); exp_f(4'b0001, "t3_f0"); step();
    for (int k = 1; k <= 3; k++) begin
      ctl_cnt = 4;
      exp_r(6'h14, 32'(k), $sformatf("t3_cnt%0d", k));
      if (k == 3) begin exp_f(4'b0101, "t3_flag"); exp_i(0, "t3_irq_early"); end
      step();
    end
    exp_r(6'h24, 32'h40004, "t3_pend"); exp_i(0, "t3_irq_wait"); step();
    exp_i(1, "t3_irq"); step();
    set_wr(6'h24, 32'h40004); exp_r(6'h24, 4, "t3_w1c"); exp_i(1, "t3_irq_lag"); step();
    exp_i(0, "t3_irq_off"); step();
    // T4 wrap, strobe collision, halt, load gating
    set_wr(6'h14, 32'hFFFFFF); exp_r(6'h14, 32'hFFFFFF, "t4_wr"); step();
    ctl_cnt = 4; exp_r(6'h14, 0, "t4_wrap"); step();
    ctl_cnt = 4; exp_r(6'h14, 1, "t4_inc"); step();
    ctl_cnt = 4; ctl_load = 4; exp_r(6'h14, 1, "t4_both"); step();
    fsm_halt = 1;
    ctl_cnt = 4; exp_r(6'h14, 1, "t4_halt_cnt"); step();
    ctl_load = 4; exp_r(6'h14, 1, "t4_halt_load"); step();
    set_wr(6'h14, 7); exp_r(6'h14, 7, "t4_halt_wr"); step();
    fsm_halt = 0; fsm_enable = 0;
    ctl_load = 4; exp_r(6'h14, 7, "t4_load_gated"); step();
    fsm_enable = 1;
    ctl_load = 4; exp_r(6'h14, 0, "t4_load_up"); step();
    // T5 bus write priority and set-wins-over-clear
    set_wr(6'h04, 9); ctl_cnt = 1; exp_r(6'h04, 9, "t5_wr_pri"); exp_f(0, "t5_flag"); step();
    set_wr(6'h04, 0); exp_r(6'h04, 0, "t5_zero"); exp_f(4'b0001, "t5_flag_up"); step();
    set_wr(6'h24, 32'h10004); exp_r(6'h24, 32'h10004, "t5_set_wins"); exp_i(0, "t5_irq_masked"); step();
    exp_i(0, "t5_irq_masked2"); step();
    // T6 reset mid-count
    ctl_load = 1; exp_r(6'h04, 5, "t6_load"); step();
    ctl_cnt = 1; exp_r(6'h04, 4, "t6_cnt"); step();
    rst = 1; ctl_cnt = 1;
    exp_r(6'h04, 0, "t6_cnt0"); exp_r(6'h00, 0, "t6_pre0"); exp_r(6'h20, 0, "t6_mode");
    exp_r(6'h24, 0, "t6_int"); exp_f(0, "t6_flag"); exp_i(0, "t6_irq");
    step();
    rst = 0;
    exp_r(6'h3C, 0, "unmapped"); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
